// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the restoring-divider controller.
//   div_state_t : 3-bit FSM state encoding (8 states)
//   DIV_WIDTH   : default operand width / iteration count
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_INIT    = 3'd2,
    S_SUB     = 3'd3,
    S_CHK     = 3'd4,
    S_RESTORE = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } div_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider loop.
//   clk, Reset : clock, async active-high reset
//   clr        : clear counter (takes priority over inc)
//   inc        : count one loop shift
//   tc         : terminal count, evaluated on the value the counter takes
//                at the coming edge (next cnt == WIDTH), so the FSM can
//                leave the loop on the same edge that records the last shift
module div_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)      cnt_nxt = '0;
    else if (inc) cnt_nxt = cnt + 1'b1;
  end

  assign tc = (cnt_nxt == TC_VAL);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/divider_control.sv
// Control FSM for a restoring shift-subtract divider datapath.
// Sequences load / initial shift / WIDTH x (subtract, check, [restore])
// / final correction, then pulses done for one cycle.
// Optional feature macro: DIV_ZERO_CHECK_EN (divide-by-zero short-cut).
// Ports:
//   clk, Reset        clock, async active-high reset
//   start             request, sampled in IDLE only
//   rem_msb           remainder sign bit after subtract
//   divisor_zero      divisor == 0 (only with DIV_ZERO_CHECK_EN)
//   rem_load, alu_sub, rem_write, rem_sll, sll_bit, rem_srl_hi
//                     datapath controls (datapath samples on negedge)
//   busy, done        status; done is a one-cycle pulse
//   div_zero_err      divide-by-zero flag, coincident with done
module divider_control
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic Reset,
  input  logic start,
  input  logic rem_msb,
  input  logic divisor_zero,
  output logic rem_load,
  output logic alu_sub,
  output logic rem_write,
  output logic rem_sll,
  output logic sll_bit,
  output logic rem_srl_hi,
  output logic busy,
  output logic done,
  output logic div_zero_err
);

  div_state_t state, state_nxt;
  logic       chk_neg;   // sign of the subtract result, held through CHK
  logic       cnt_inc, cnt_clr, cnt_tc;

  // The datapath writes the subtract result at the SUB negedge, so rem_msb
  // is valid at the SUB->CHK edge. It changes again at the CHK negedge
  // (restore or shift), so the CHK decision is taken from this captured copy
  // to keep both the CHK controls and the CHK exit consistent.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)              chk_neg <= 1'b0;
    else if (state == S_SUB) chk_neg <= rem_msb;
  end

  assign cnt_inc = ((state == S_CHK) && !chk_neg) || (state == S_RESTORE);
  assign cnt_clr = (state == S_DONE);

  div_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .tc    (cnt_tc)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic zero_hit, zerr_q;
  assign zero_hit = (state == S_IDLE) && start && divisor_zero;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) zerr_q <= 1'b0;
    else       zerr_q <= zero_hit;
  end

  assign div_zero_err = zerr_q && (state == S_DONE);
`else
  logic zero_hit;
  logic unused_divisor_zero;
  assign zero_hit            = 1'b0;
  assign unused_divisor_zero = divisor_zero;
  assign div_zero_err        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (zero_hit)   state_nxt = S_DONE;
                 else if (start) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_INIT;
      S_INIT:    state_nxt = S_SUB;
      S_SUB:     state_nxt = S_CHK;
      S_CHK:     if (chk_neg)    state_nxt = S_RESTORE;
                 else            state_nxt = cnt_tc ? S_FINAL : S_SUB;
      S_RESTORE: state_nxt = cnt_tc ? S_FINAL : S_SUB;
      S_FINAL:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    rem_load   = 1'b0;
    alu_sub    = 1'b0;
    rem_write  = 1'b0;
    rem_sll    = 1'b0;
    sll_bit    = 1'b0;
    rem_srl_hi = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE:    busy = 1'b0;
      S_LOAD:    rem_load = 1'b1;
      S_INIT:    rem_sll  = 1'b1;
      S_SUB:     begin alu_sub = 1'b1; rem_write = 1'b1; end
      S_CHK:     if (chk_neg) rem_write = 1'b1;          // add divisor back
                 else begin rem_sll = 1'b1; sll_bit = 1'b1; end
      S_RESTORE: rem_sll = 1'b1;
      S_FINAL:   rem_srl_hi = 1'b1;
      S_DONE:    begin busy = 1'b0; done = 1'b1; end
      default:   busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_divider_control.sv
module tb_divider_control;
  localparam int W = 32;

  logic clk = 1'b0;
  logic Reset, start;
  logic rem_msb, divisor_zero;
  logic rem_load, alu_sub, rem_write, rem_sll, sll_bit, rem_srl_hi;
  logic busy, done, div_zero_err;

  logic [W-1:0]   dividend = '0, divisor = '0;
  logic [2*W-1:0] rem = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_control dut (
    .clk(clk), .Reset(Reset), .start(start), .rem_msb(rem_msb),
    .divisor_zero(divisor_zero), .rem_load(rem_load), .alu_sub(alu_sub),
    .rem_write(rem_write), .rem_sll(rem_sll), .sll_bit(sll_bit),
    .rem_srl_hi(rem_srl_hi), .busy(busy), .done(done),
    .div_zero_err(div_zero_err)
  );

  // Datapath stand-in: remainder register + ALU, sampling controls on negedge.
  assign rem_msb      = rem[2*W-1];
  assign divisor_zero = (divisor == '0);
  always @(negedge clk) begin
    if (rem_load)        rem <= {{W{1'b0}}, dividend};
    else if (rem_write)  rem[2*W-1:W] <= alu_sub ? rem[2*W-1:W] - divisor
                                                 : rem[2*W-1:W] + divisor;
    else if (rem_sll)    rem <= {rem[2*W-2:0], sll_bit};
    else if (rem_srl_hi) rem[2*W-1:W] <= {1'b0, rem[2*W-1:W+1]};
  end

  function automatic logic [8:0] outs();
    return {rem_load, alu_sub, rem_write, rem_sll, sll_bit, rem_srl_hi,
            busy, done, div_zero_err};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Long division on plain integers: a quotient bit of 0 means that
  // iteration needed a restore (one extra cycle).
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int nres);
    longint unsigned pr = 0;
    q = '0; nres = 0;
    for (int i = W-1; i >= 0; i--) begin
      pr = pr * 2 + longint'(a[i]);
      if (pr >= longint'(b)) begin pr = pr - longint'(b); q[i] = 1'b1; end
      else nres++;
    end
    r = W'(pr);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Caller sits at posedge+1 in IDLE. With prestarted=1 the accept edge has
  // already happened and we are in cycle 1.
  task automatic run_div(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit prestarted);
    logic [W-1:0] eq, er;
    int nres, c, busy_bad, lat_exp;
    dividend = a; divisor = b;
    ref_div(a, b, eq, er, nres);
    lat_exp = 4 + 2*W + nres;
    if (!prestarted) begin start = 1'b1; step(); end
    start = 1'b0;
    c = 1; busy_bad = 0;
    while (!done && c < 200) begin
      if (!busy) busy_bad++;
      step(); c++;
    end
    chk({tag, "_latency"}, 64'(c), 64'(lat_exp));
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    chk({tag, "_done_busy"}, {62'd0, done, busy}, 64'b10);
    chk({tag, "_zerr"}, 64'(div_zero_err), 64'd0);
    chk({tag, "_quot"}, 64'(rem[W-1:0]), 64'(eq));
    chk({tag, "_rem"}, 64'(rem[2*W-1:W]), 64'(er));
    step();
    chk({tag, "_pulse"}, {62'd0, done, busy}, 64'b00);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    Reset = 1'b1; start = 1'b1;

    // Reset with start held: nothing moves.
    step(); step(); step();
    chk("rst_outs", 64'(outs()), 64'd0);
    Reset = 1'b0;
    chk("rst_rel_idle", 64'(outs()), 64'd0);
    dividend = 32'd0; divisor = 32'd5;
    step();
    chk("accept_load", {62'd0, rem_load, busy}, 64'b11);
    run_div("d0_by_5", 32'd0, 32'd5, 1'b1);

    run_div("ffff_by_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("100_by_7", 32'd100, 32'd7, 1'b0);

    // Abort mid-loop.
    dividend = 32'd100; divisor = 32'd7;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 25; i++) step();
    chk("abort_busy", 64'(busy), 64'd1);
    Reset = 1'b1; #1;
    chk("abort_outs", 64'(outs()), 64'd0);
    step(); step();
    chk("abort_hold", 64'(outs()), 64'd0);
    Reset = 1'b0;
    step();
    chk("abort_no_done", 64'(outs()), 64'd0);
    run_div("restart_100_7", 32'd100, 32'd7, 1'b0);

`ifdef DIV_ZERO_CHECK_EN
    dividend = 32'd12345; divisor = 32'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("dz_done", 64'(outs()), 64'b0_0000_0011);
    step();
    chk("dz_idle", 64'(outs()), 64'd0);
`else
    run_div("div_by_0", 32'd12345, 32'd0, 1'b0);
`endif

    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? W'($urandom_range(15, 1)) : (($urandom & 32'h7FFF_FFFF) | 32'd1);
      run_div($sformatf("rnd%0d", k), ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
